// File: rtl/control_unit.sv
// control_unit -- instruction-sequencing FSM for the 16-bit processor.
//
// Owns PC and IR, fetches from a synchronous instruction ROM (data valid one
// cycle after PC_out changes), decodes the opcode in IR[15:12] and drives the
// datapath control strobes for each instruction's execute cycles.
//
// Optional build macro: CU_SINGLE_STEP_EN
//   defined   : adds input `step`; Fetch holds (PC/IR unchanged, strobes 0)
//               until a posedge with step=1.
//   undefined : no step port; Fetch always lasts one cycle.
//
// Ports:
//   clk         system clock, all state changes on posedge
//   reset_n     asynchronous active-low reset
//   step        (CU_SINGLE_STEP_EN only) single-step enable, sampled in Fetch
//   instr_data  instruction-ROM read data
//   PC_out      instruction-ROM address
//   IR_out      current instruction register (monitoring)
//   state_out   current FSM state encoding (monitoring / debug)
//   D_addr      data-memory address
//   D_wr        data-memory write enable
//   RF_sel      write-back select: 1 = data memory, 0 = ALU
//   WriteAddr   register-file write address
//   rdAddrA     register-file read address A
//   rdAddrB     register-file read address B
//   RF_W_en     register-file write enable
//   ALU_s0      ALU function: 0 = pass/zero, 1 = A+B, 2 = A-B
//   halted      high while in Halt
module control_unit #(
  parameter int PC_W    = 7,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
`ifdef CU_SINGLE_STEP_EN
  input  logic               step,
`endif
  input  logic [INSTR_W-1:0] instr_data,
  output logic [PC_W-1:0]    PC_out,
  output logic [INSTR_W-1:0] IR_out,
  output logic [3:0]         state_out,
  output logic [7:0]         D_addr,
  output logic               D_wr,
  output logic               RF_sel,
  output logic [3:0]         WriteAddr,
  output logic [3:0]         rdAddrA,
  output logic [3:0]         rdAddrB,
  output logic               RF_W_en,
  output logic [2:0]         ALU_s0,
  output logic               halted
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOADA  = 4'd3,
    S_LOADB  = 4'd4,
    S_STORE  = 4'd5,
    S_ADD    = 4'd6,
    S_SUB    = 4'd7,
    S_NOOP   = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic               fetch_go;

`ifdef CU_SINGLE_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  // State, PC and IR registers. PC/IR only move on a taken Fetch; the PC
  // increment wraps naturally at 2^PC_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_INIT;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == S_FETCH && fetch_go) begin
        ir <= instr_data;
        pc <= pc + 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_INIT:   state_next = S_FETCH;
      S_FETCH:  state_next = fetch_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (ir[15:12])
          4'h1:    state_next = S_STORE;
          4'h2:    state_next = S_LOADA;
          4'h3:    state_next = S_ADD;
          4'h4:    state_next = S_SUB;
          4'h5:    state_next = S_HALT;
          default: state_next = S_NOOP;  // 0x0 and illegal 0x6..0xF
        endcase
      end
      S_LOADA:  state_next = S_LOADB;
      S_LOADB:  state_next = S_FETCH;
      S_STORE:  state_next = S_FETCH;
      S_ADD:    state_next = S_FETCH;
      S_SUB:    state_next = S_FETCH;
      S_NOOP:   state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_INIT;
    endcase
  end

  // Moore control outputs decoded from state and IR. Because they depend only
  // on registered state, an asynchronous reset clears them at once.
  always_comb begin
    D_addr    = 8'h00;
    D_wr      = 1'b0;
    RF_sel    = 1'b0;
    WriteAddr = 4'h0;
    rdAddrA   = 4'h0;
    rdAddrB   = 4'h0;
    RF_W_en   = 1'b0;
    ALU_s0    = 3'd0;
    halted    = 1'b0;
    case (state)
      S_LOADA, S_LOADB: begin
        D_addr    = ir[11:4];
        RF_sel    = 1'b1;
        WriteAddr = ir[3:0];
        // Write only in the second cycle, once the RAM read data is valid.
        RF_W_en   = (state == S_LOADB);
      end
      S_STORE: begin
        D_addr  = ir[7:0];
        rdAddrA = ir[11:8];
        D_wr    = 1'b1;
      end
      S_ADD, S_SUB: begin
        rdAddrA   = ir[11:8];
        rdAddrB   = ir[7:4];
        WriteAddr = ir[3:0];
        ALU_s0    = (state == S_ADD) ? 3'd1 : 3'd2;
        RF_W_en   = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign PC_out    = pc;
  assign IR_out    = ir;
  assign state_out = state;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit -- self-checking bench for control_unit.
// A behavioural synchronous ROM feeds the DUT. Expected per-cycle output
// vectors are pushed to exp_q when a program is loaded and popped/compared
// cycle by cycle while the DUT runs it.
module tb_control_unit;

  localparam int VW = 54;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instr_data = 16'h0000;
  logic [6:0]  PC_out;
  logic [15:0] IR_out;
  logic [3:0]  state_out;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic        RF_sel;
  logic [3:0]  WriteAddr;
  logic [3:0]  rdAddrA;
  logic [3:0]  rdAddrB;
  logic        RF_W_en;
  logic [2:0]  ALU_s0;
  logic        halted;
`ifdef CU_SINGLE_STEP_EN
  logic        step = 1'b1;
`endif

  logic [15:0]   rom [0:127];
  logic [VW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_pass = 0;

  control_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
`ifdef CU_SINGLE_STEP_EN
    .step       (step),
`endif
    .instr_data (instr_data),
    .PC_out     (PC_out),
    .IR_out     (IR_out),
    .state_out  (state_out),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_sel     (RF_sel),
    .WriteAddr  (WriteAddr),
    .rdAddrA    (rdAddrA),
    .rdAddrB    (rdAddrB),
    .RF_W_en    (RF_W_en),
    .ALU_s0     (ALU_s0),
    .halted     (halted)
  );

  // ---------------- clock / ROM ----------------
  always #5 clk = ~clk;

  always @(posedge clk) instr_data <= rom[PC_out];

  // ---------------- vector helpers ----------------
  function automatic logic [VW-1:0] vec(input logic hlt, input logic [3:0] st,
                                        input logic [15:0] ir, input logic [6:0] pc,
                                        input logic [7:0] da, input logic dwr,
                                        input logic rfs, input logic [3:0] wa,
                                        input logic [3:0] ra, input logic [3:0] rb,
                                        input logic wen, input logic [2:0] alu);
    return {hlt, st, ir, pc, da, dwr, rfs, wa, ra, rb, wen, alu};
  endfunction

  function automatic logic [VW-1:0] obs();
    return {halted, state_out, IR_out, PC_out, D_addr, D_wr, RF_sel,
            WriteAddr, rdAddrA, rdAddrB, RF_W_en, ALU_s0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_program();
    for (int i = 0; i < 128; i++) rom[i] = 16'h3FFF;
    rom[0] = 16'h2011;
    rom[1] = 16'h116A;
    rom[2] = 16'h3123;
    rom[3] = 16'h4021;
    rom[4] = 16'hF000;
    rom[5] = 16'h5000;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [VW-1:0] got;
    load_program();
    hold_reset();
    #1 got = obs();
    n_checks++;
    if (got !== '0) $display("FAIL reset_outputs: got %h want %h", got, {VW{1'b0}});
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    #1 got = obs();
    n_checks++;
    if (got !== vec(0, 4'd0, 16'h0, 7'd0, 8'h0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 3'd0))
      $display("FAIL reset_init: got %h", got);
    else n_pass++;
    @(negedge clk);
    #1 got = obs();
    n_checks++;
    if (got !== vec(0, 4'd1, 16'h0, 7'd0, 8'h0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 3'd0))
      $display("FAIL reset_fetch: got %h", got);
    else n_pass++;
  endtask

  task automatic test_program();
    logic [VW-1:0] got;
    logic [VW-1:0] exp;
    int            cyc;
    load_program();
    hold_reset();
    // Expected trace from Init through Halt, one vector per cycle.
    exp_q.push_back(vec(0, 4'd0, 16'h0000, 7'd0, 8'h00, 0, 0, 4'h0, 4'h0, 4'h0, 0, 3'd0));
    exp_q.push_back(vec(0, 4'd1, 16'h0000, 7'd0, 8'h00, 0, 0, 4'h0, 4'h0, 4'h0, 0, 3'd0));
    exp_q.push_back(vec(0, 4'd2, 16'h2011, 7'd1, 8'h00, 0, 0, 4'h0, 4'h0, 4'h0, 0, 3'd0));
    exp_q.push_back(vec(0, 4'd3, 16'h2011, 7'd1, 8'h01, 0, 1, 4'h1, 4'h0, 4'h0, 0, 3'd0));
    exp_q.push_back(vec(0, 4'd4, 16'h2011, 7'd1, 8'h01, 0, 1, 4'h1, 4'h0, 4'h0, 1, 3'd0));
    exp_q.push_back(vec(0, 4'd1, 16'h2011, 7'd1, 8'h00, 0, 0, 4'h0, 4'h0, 4'h0, 0, 3'd0));
    exp_q.push_back(vec(0, 4'd2, 16'h116A, 7'd2, 8'h00, 0, 0, 4'h0, 4'h0, 4'h0, 0, 3'd0));
    exp_q.push_back(vec(0, 4'd5, 16'h116A, 7'd2, 8'h6A, 1, 0, 4'h0, 4'h1, 4'h0, 0, 3'd0));
    exp_q.push_back(vec(0, 4'd1, 16'h116A, 7'd2, 8'h00, 0, 0, 4'h0, 4'h0, 4'h0, 0, 3'd0));
    exp_q.push_back(vec(0, 4'd2, 16'h3123, 7'd3, 8'h00, 0, 0, 4'h0, 4'h0, 4'h0, 0, 3'd0));
    exp_q.push_back(vec(0, 4'd6, 16'h3123, 7'd3, 8'h00, 0, 0, 4'h3, 4'h1, 4'h2, 1, 3'd1));
    exp_q.push_back(vec(0, 4'd1, 16'h3123, 7'd3, 8'h00, 0, 0, 4'h0, 4'h0, 4'h0, 0, 3'd0));
    exp_q.push_back(vec(0, 4'd2, 16'h4021, 7'd4, 8'h00, 0, 0, 4'h0, 4'h0, 4'h0, 0, 3'd0));
    exp_q.push_back(vec(0, 4'd7, 16'h4021, 7'd4, 8'h00, 0, 0, 4'h1, 4'h0, 4'h2, 1, 3'd2));
    exp_q.push_back(vec(0, 4'd1, 16'h4021, 7'd4, 8'h00, 0, 0, 4'h0, 4'h0, 4'h0, 0, 3'd0));
    exp_q.push_back(vec(0, 4'd2, 16'hF000, 7'd5, 8'h00, 0, 0, 4'h0, 4'h0, 4'h0, 0, 3'd0));
    exp_q.push_back(vec(0, 4'd8, 16'hF000, 7'd5, 8'h00, 0, 0, 4'h0, 4'h0, 4'h0, 0, 3'd0));
    exp_q.push_back(vec(0, 4'd1, 16'hF000, 7'd5, 8'h00, 0, 0, 4'h0, 4'h0, 4'h0, 0, 3'd0));
    exp_q.push_back(vec(0, 4'd2, 16'h5000, 7'd6, 8'h00, 0, 0, 4'h0, 4'h0, 4'h0, 0, 3'd0));
    for (int i = 0; i < 22; i++)
      exp_q.push_back(vec(1, 4'd9, 16'h5000, 7'd6, 8'h00, 0, 0, 4'h0, 4'h0, 4'h0, 0, 3'd0));
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0) begin
      #1 got = obs();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL program_cycle%0d: got %h want %h", cyc, got, exp);
      else n_pass++;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_restart_and_mid_load_reset();
    logic [VW-1:0] got;
    // Restart out of Halt.
    reset_n = 1'b0;
    #1 got = obs();
    n_checks++;
    if (got !== '0) $display("FAIL halt_reset_outputs: got %h want 0", got);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1 n_checks++;
    if ({state_out, PC_out} !== {4'd1, 7'd0})
      $display("FAIL restart_fetch: got state %0d pc %0d want 1 0", state_out, PC_out);
    else n_pass++;
    @(negedge clk);
    #1 n_checks++;
    if ({state_out, IR_out, PC_out} !== {4'd2, 16'h2011, 7'd1})
      $display("FAIL restart_decode: got state %0d ir %h pc %0d want 2 2011 1",
               state_out, IR_out, PC_out);
    else n_pass++;
    @(negedge clk);
    #1 n_checks++;
    if (state_out !== 4'd3) $display("FAIL mid_load_reach: got state %0d want 3", state_out);
    else n_pass++;
    // Assert reset in the middle of LoadA.
    reset_n = 1'b0;
    #1 got = obs();
    n_checks++;
    if (got !== '0) $display("FAIL mid_load_outputs: got %h want 0", got);
    else n_pass++;
    @(posedge clk);
    #1 n_checks++;
    if ({state_out, RF_W_en} !== {4'd0, 1'b0})
      $display("FAIL mid_load_no_write: got state %0d wen %b want 0 0", state_out, RF_W_en);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    #1 n_checks++;
    if (state_out !== 4'd0) $display("FAIL mid_load_init: got state %0d want 0", state_out);
    else n_pass++;
    @(negedge clk);
    #1 n_checks++;
    if ({state_out, PC_out} !== {4'd1, 7'd0})
      $display("FAIL mid_load_fetch: got state %0d pc %0d want 1 0", state_out, PC_out);
    else n_pass++;
  endtask

  task automatic test_pc_wrap();
    int  budget;
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    hold_reset();
    reset_n = 1'b1;
    budget = 0;
    while (PC_out !== 7'd127 && budget < 600) begin
      @(negedge clk);
      budget++;
    end
    n_checks++;
    if (PC_out !== 7'd127) $display("FAIL wrap_reach: got pc %0d want 127", PC_out);
    else n_pass++;
    // Now in Decode of instr 126; Noop, Fetch(127), then Decode with PC 0.
    @(negedge clk);
    @(negedge clk);
    #1 n_checks++;
    if ({state_out, PC_out} !== {4'd1, 7'd127})
      $display("FAIL wrap_fetch: got state %0d pc %0d want 1 127", state_out, PC_out);
    else n_pass++;
    @(negedge clk);
    #1 n_checks++;
    if ({state_out, PC_out, D_wr, RF_W_en} !== {4'd2, 7'd0, 1'b0, 1'b0})
      $display("FAIL wrap_zero: got state %0d pc %0d want 2 0", state_out, PC_out);
    else n_pass++;
  endtask

`ifdef CU_SINGLE_STEP_EN
  task automatic test_single_step();
    load_program();
    step = 1'b0;
    hold_reset();
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    #1 n_checks++;
    if ({state_out, IR_out, PC_out} !== {4'd1, 16'h0000, 7'd0})
      $display("FAIL step_hold: got state %0d ir %h pc %0d want 1 0000 0",
               state_out, IR_out, PC_out);
    else n_pass++;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    #1 n_checks++;
    if ({state_out, IR_out, PC_out} !== {4'd2, 16'h2011, 7'd1})
      $display("FAIL step_advance: got state %0d ir %h pc %0d want 2 2011 1",
               state_out, IR_out, PC_out);
    else n_pass++;
    repeat (6) @(negedge clk);
    #1 n_checks++;
    if ({state_out, IR_out, PC_out} !== {4'd1, 16'h2011, 7'd1})
      $display("FAIL step_one_instr: got state %0d ir %h pc %0d want 1 2011 1",
               state_out, IR_out, PC_out);
    else n_pass++;
    step = 1'b1;
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_program();
    test_restart_and_mid_load_reset();
    test_pc_wrap();
`ifdef CU_SINGLE_STEP_EN
    test_single_step();
`endif
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global timeout guard.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
